cvtintseq: RTL

Multi-cycle sequencer for the floating-point-to-integer conversion back end in the FPU post-processing path. It accepts a normalized magnitude from the normalization shifter through a valid/ready handshake, then runs it through three steps: round/negate, saturation check, result hold. It delivers an XLEN-wide integer with NV/NX flags to the writeback side. It owns the shared round/negate resource, so only one conversion is in flight at a time.

---
 rtl/cvtintseq_pkg.sv | 20 ++
 rtl/cvtintseq_sat.sv | 59 +++++
 rtl/cvtintseq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cvtintseq_pkg.sv
// Shared FPU definitions for the float-to-integer conversion back end:
// sequencer state encoding and the 32/64-bit saturation limits.
package cvtintseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } cvtstate_t;

    // 32-bit limits are stored unextended; the sequencer sign-extends W=32 results.
    localparam logic [63:0] SMAX32 = 64'h0000_0000_7FFF_FFFF;
    localparam logic [63:0] SMIN32 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] UMAX32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] SMAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SMIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] UMAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/cvtintseq_sat.sv
// cvtintsat: combinational saturation of the rounded/negated value to the
// destination width, producing the clamped result and the invalid flag.
module cvtintsat
    import cvtintseq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN+1:0] negres,
    input  logic            prenz,
    input  logic            xs,
    input  logic            issigned,
    input  logic            int64,
    input  logic            nan,
    output logic [XLEN-1:0] result,
    output logic            nv
);

    logic [6:0]             wsh;
    logic signed [XLEN+1:0] hi_s;
    logic [XLEN+1:0]        hi_u;
    logic                   inrange_s;
    logic                   ovf_u;
    logic [XLEN-1:0]        smax;
    logic [XLEN-1:0]        smin;
    logic [XLEN-1:0]        umax;

    // In signed range iff every bit from W-1 upward is a copy of the sign.
    always_comb begin
        wsh       = int64 ? 7'd63 : 7'd31;
        hi_s      = $signed(negres) >>> wsh;
        inrange_s = (hi_s == '0) || (hi_s == '1);
        hi_u      = negres >> (wsh + 7'd1);
        ovf_u     = |hi_u;
        smax      = int64 ? XLEN'(SMAX64) : XLEN'(SMAX32);
        smin      = int64 ? XLEN'(SMIN64) : XLEN'(SMIN32);
        umax      = int64 ? XLEN'(UMAX64) : XLEN'(UMAX32);
    end

    always_comb begin
        result = negres[XLEN-1:0];
        nv     = 1'b0;
        if (nan) begin
            result = issigned ? smax : umax;
            nv     = 1'b1;
        end else if (issigned) begin
            if (!inrange_s) begin
                result = xs ? smin : smax;
                nv     = 1'b1;
            end
        end else if (xs && prenz) begin
            result = '0;
            nv     = 1'b1;
        end else if (ovf_u) begin
            result = umax;
            nv     = 1'b1;
        end
    end

endmodule

// File: rtl/cvtintseq.sv
// Float-to-integer conversion sequencer: round/negate, optional saturation
// check (CVTINT_SAT_EN), then hold the result until the consumer takes it.
module cvtintseq
    import cvtintseq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Flush,
    input  logic            CvtValid,
    output logic            CvtReady,
    input  logic [XLEN-1:0] Mag,
    input  logic            Plus1,
    input  logic            Xs,
    input  logic            Signed,
    input  logic            Int64,
    input  logic            NaNIn,
    input  logic            Inexact,
    output logic            ResultValid,
    input  logic            ResultReady,
    output logic [XLEN-1:0] Result,
    output logic            NV,
    output logic            NX,
    output logic [1:0]      dbgstate
);

    // Handshakes: a transfer happens on an edge where valid & ready are both
    // high; valid never waits on ready and both are driven only from state.
    cvtstate_t       st, nst;
    logic [XLEN-1:0] mag_q;
    logic            plus1_q, xs_q, i64_q, inx_q;
    logic [XLEN-1:0] result_q;
    logic            nv_q, nx_q;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v, input logic w64);
        logic [XLEN-1:0] r;
        r = v;
        if (!w64) begin
            for (int i = 32; i < XLEN; i++) r[i] = v[31];
        end
        return r;
    endfunction

    always_comb begin
        nst = st;
        case (st)
            IDLE:  if (CvtValid) nst = ROUND;
`ifdef CVTINT_SAT_EN
            ROUND: nst = CHECK;
`else
            ROUND: nst = DONE;
`endif
            CHECK: nst = DONE;
            DONE:  if (ResultReady) nst = IDLE;
            default: nst = IDLE;
        endcase
        if (Flush) nst = IDLE;
    end

    assign CvtReady    = (st == IDLE);
    assign ResultValid = (st == DONE);
    assign Result      = result_q;
    assign NV          = nv_q;
    assign NX          = nx_q;
    assign dbgstate    = st;

`ifdef CVTINT_SAT_EN
    logic            sgn_q, nan_q;
    logic [XLEN+1:0] preres_c, negres_c, negres_q;
    logic            prenz_q;
    logic [XLEN-1:0] sat_res;
    logic            sat_nv;

    always_comb begin
        preres_c = {2'b00, mag_q} + (XLEN+2)'(plus1_q);
        negres_c = xs_q ? -preres_c : preres_c;
    end

    cvtintsat #(.XLEN(XLEN)) u_sat (
        .negres   (negres_q),
        .prenz    (prenz_q),
        .xs       (xs_q),
        .issigned (sgn_q),
        .int64    (i64_q),
        .nan      (nan_q),
        .result   (sat_res),
        .nv       (sat_nv)
    );

    always_ff @(posedge clk) begin
        if (st == IDLE && CvtValid && !Flush) begin
            sgn_q <= Signed;
            nan_q <= NaNIn;
        end
        if (st == ROUND) begin
            negres_q <= negres_c;
            prenz_q  <= |preres_c;
        end
    end
`else
    logic [XLEN-1:0] lowres_c;
    logic            unused_sat;

    // Only the low XLEN bits survive without saturation, so no carry-out is kept.
    always_comb begin
        lowres_c = mag_q + XLEN'(plus1_q);
        if (xs_q) lowres_c = -lowres_c;
    end

    assign unused_sat = ^{Signed, NaNIn};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            result_q <= '0;
            nv_q     <= 1'b0;
            nx_q     <= 1'b0;
        end else begin
            st <= nst;
            if (st == IDLE && CvtValid && !Flush) begin
                mag_q   <= Mag;
                plus1_q <= Plus1;
                xs_q    <= Xs;
                i64_q   <= Int64;
                inx_q   <= Inexact;
            end
`ifdef CVTINT_SAT_EN
            if (st == CHECK) begin
                result_q <= sext32(sat_res, i64_q);
                nv_q     <= sat_nv;
                nx_q     <= inx_q & ~sat_nv;
            end
`else
            if (st == ROUND) begin
                result_q <= sext32(lowres_c, i64_q);
                nv_q     <= 1'b0;
                nx_q     <= inx_q;
            end
`endif
        end
    end

endmodule
